// File: rtl/vip_stream_encoder.sv
// Output-side VIP encoder: turns core pixel beats into an Avalon-ST control packet plus video packet per frame.
// Optional define VIP_ENC_PIX_CHECK_EN adds frame-size checking against width*height with a pix_err pulse.
module vip_stream_encoder #(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        write,
  output logic                                        stall_out,
  input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] data_in,
  input  logic                                        end_of_video_in,
  input  logic [15:0]                                 width_in,
  input  logic [15:0]                                 height_in,
  input  logic [3:0]                                  interlaced_in,
  input  logic                                        vip_ctrl_send,
  output logic                                        vip_ctrl_busy,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
  output logic                                        dout_valid,
  input  logic                                        dout_ready,
  output logic                                        dout_sop,
  output logic                                        dout_eop
`ifdef VIP_ENC_PIX_CHECK_EN
  ,
  output logic                                        pix_err
`endif
);

  localparam int DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    C_HDR     = 3'd1,
    C_BODY    = 3'd2,
    V_HDR     = 3'd3,
    VID_DATA  = 3'd4,
    V_DRAIN   = 3'd5
`ifdef VIP_ENC_PIX_CHECK_EN
    ,
    V_DISCARD = 3'd6
`endif
  } state_t;

  state_t state, state_nxt;

  // Control-packet symbols carry one nibble each in the low bits; symbol0 is the low byte.
  function automatic logic [DW-1:0] ctrl_beat(input logic [3:0] s0, input logic [3:0] s1,
                                              input logic [3:0] s2);
    logic [DW-1:0] b;
    b = '0;
    b[0 +: 4]                   = s0;
    b[BITS_PER_SYMBOL +: 4]     = s1;
    b[2*BITS_PER_SYMBOL +: 4]   = s2;
    return b;
  endfunction

  logic [15:0] shadow_w, shadow_h, act_w, act_h;
  logic [3:0]  shadow_i, act_i;
  logic        pending;
  logic [1:0]  body_cnt;
  logic        frame_start;

  logic [DW:0]  fifo_mem [FIFO_DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         fifo_empty, fifo_full, fifo_st;
  logic         vid_acc, fifo_rd;
  logic [DW:0]  ent_p0;
  logic [DW:0]  head_p1;
  logic         vld_p1;
  logic         wr_eov;
  logic         limit_hit;

  assign frame_start = (state == IDLE) && write;
  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign vld_p1      = ~fifo_empty;
  assign head_p1     = fifo_mem[rd_ptr[AW-1:0]];

`ifdef VIP_ENC_PIX_CHECK_EN
  assign fifo_st = (state == VID_DATA) || (state == V_DRAIN) || (state == V_DISCARD);
`else
  assign fifo_st = (state == VID_DATA) || (state == V_DRAIN);
`endif

  // Acceptance and drain are derived from registered state only, never from stall_out itself.
  assign vid_acc = (state == VID_DATA) && write && !fifo_full;
  assign fifo_rd = fifo_st && vld_p1 && dout_ready;

`ifdef VIP_ENC_PIX_CHECK_EN
  logic [31:0] pix_cnt, pix_cnt_nxt, frame_area;
  logic        early_eov;

  assign frame_area  = 32'(act_w) * 32'(act_h);
  assign pix_cnt_nxt = pix_cnt + 32'd1;
  assign limit_hit   = vid_acc && !end_of_video_in && (pix_cnt_nxt == frame_area);
  assign early_eov   = vid_acc && end_of_video_in && (pix_cnt_nxt < frame_area);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt <= '0;
      pix_err <= 1'b0;
    end else begin
      pix_err <= early_eov || limit_hit;
      if (frame_start)
        pix_cnt <= '0;
      else if (vid_acc)
        pix_cnt <= pix_cnt_nxt;
    end
  end
`else
  assign limit_hit = 1'b0;
`endif

  assign wr_eov = end_of_video_in || limit_hit;
  assign ent_p0 = {wr_eov, data_in};

  // ---- stage p0: pixel enters the FIFO ----
  always_ff @(posedge clk) begin
    if (vid_acc)
      fifo_mem[wr_ptr[AW-1:0]] <= ent_p0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (vid_acc)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (fifo_rd)
        rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_w <= 16'd640;
      shadow_h <= 16'd480;
      shadow_i <= 4'd0;
      act_w    <= 16'd640;
      act_h    <= 16'd480;
      act_i    <= 4'd0;
      pending  <= 1'b0;
    end else begin
      // A send coinciding with frame start leaves the new format pending for the next frame.
      if (frame_start) begin
        act_w <= shadow_w;
        act_h <= shadow_h;
        act_i <= shadow_i;
      end
      if (vip_ctrl_send) begin
        shadow_w <= width_in;
        shadow_h <= height_in;
        shadow_i <= interlaced_in;
        pending  <= 1'b1;
      end else if (frame_start) begin
        pending  <= 1'b0;
      end
    end
  end

  assign vip_ctrl_busy = pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      body_cnt <= 2'd0;
    else if (state == C_BODY && dout_ready)
      body_cnt <= (body_cnt == 2'd2) ? 2'd0 : body_cnt + 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // ---- stage p1: FIFO head or header beat drives the stream ----
  always_comb begin
    state_nxt  = state;
    stall_out  = 1'b1;
    dout_valid = 1'b0;
    dout_sop   = 1'b0;
    dout_eop   = 1'b0;
    dout_data  = '0;
    case (state)
      IDLE: begin
        if (write)
          state_nxt = C_HDR;
      end
      C_HDR: begin
        dout_valid = 1'b1;
        dout_sop   = 1'b1;
        dout_data  = ctrl_beat(4'hF, 4'h0, 4'h0);
        if (dout_ready)
          state_nxt = C_BODY;
      end
      C_BODY: begin
        dout_valid = 1'b1;
        case (body_cnt)
          2'd0:    dout_data = ctrl_beat(act_w[15:12], act_w[11:8], act_w[7:4]);
          2'd1:    dout_data = ctrl_beat(act_w[3:0], act_h[15:12], act_h[11:8]);
          default: begin
            dout_data = ctrl_beat(act_h[7:4], act_h[3:0], act_i);
            dout_eop  = 1'b1;
          end
        endcase
        if (dout_ready && body_cnt == 2'd2)
          state_nxt = V_HDR;
      end
      V_HDR: begin
        dout_valid = 1'b1;
        dout_sop   = 1'b1;
        if (dout_ready)
          state_nxt = VID_DATA;
      end
      VID_DATA: begin
        stall_out = fifo_full;
`ifdef VIP_ENC_PIX_CHECK_EN
        if (vid_acc && wr_eov)
          state_nxt = limit_hit ? V_DISCARD : V_DRAIN;
`else
        if (vid_acc && wr_eov)
          state_nxt = V_DRAIN;
`endif
      end
      V_DRAIN: begin
        if (fifo_empty || (fifo_rd && head_p1[DW]))
          state_nxt = IDLE;
      end
`ifdef VIP_ENC_PIX_CHECK_EN
      V_DISCARD: begin
        stall_out = 1'b0;
        if (write && end_of_video_in)
          state_nxt = V_DRAIN;
      end
`endif
      default: state_nxt = IDLE;
    endcase

    if (fifo_st) begin
      dout_valid = vld_p1;
      dout_eop   = vld_p1 && head_p1[DW];
      dout_data  = vld_p1 ? head_p1[DW-1:0] : '0;
    end
  end

endmodule
